// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - raster-order result-memory writer for the Sobel edge stream
// Optional feature macro BORDER_FILL_EN: traverse the full frame and write zeros on the border.
module pixel_writer #(
    parameter int ImgWidth  = 256,
    parameter int ImgHeight = 256,
    parameter int DataBit   = 8,
    parameter int AddrBit   = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic               InValid,
    input  logic [DataBit-1:0] InData,
    output logic               InReady,
    output logic               MemWE,
    output logic [AddrBit-1:0] MemAddr,
    output logic [DataBit-1:0] MemData,
    output logic               Busy,
    output logic               Done
);

`ifdef BORDER_FILL_EN
    localparam int Cols = ImgWidth;
    localparam int Rows = ImgHeight;
`else
    localparam int Cols = ImgWidth - 2;
    localparam int Rows = ImgHeight - 2;
`endif
    localparam int ColBit = $clog2(Cols + 1);
    localparam int RowBit = $clog2(Rows + 1);
    localparam logic [ColBit-1:0] ColLast = ColBit'(Cols - 1);
    localparam logic [RowBit-1:0] RowLast = RowBit'(Rows - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [RowBit-1:0]  row_q;
    logic [ColBit-1:0]  col_q;
    logic [AddrBit-1:0] idx_q;
    logic               mem_we_q;
    logic [AddrBit-1:0] mem_addr_q;
    logic [DataBit-1:0] mem_data_q;
    logic               busy_q;
    logic               done_q;

    logic border;
    logic last_pos;
    logic advance;

    always_comb begin
`ifdef BORDER_FILL_EN
        border = (row_q == '0) || (row_q == RowLast) || (col_q == '0) || (col_q == ColLast);
`else
        border = 1'b0;
`endif
        last_pos = (row_q == RowLast) && (col_q == ColLast);
        InReady  = (state_q == RUN) && !border;
        // Border positions self-advance; interior ones need an accepted pixel.
        advance  = (state_q == RUN) && (border || InValid);
    end

    // The raster index equals Row*ImgWidth+Col in the full-frame build and the
    // compact interior index otherwise, so one incrementing counter serves both.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            idx_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= (state_q == RUN) || Start;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= RUN;
                        row_q   <= '0;
                        col_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= idx_q;
                        mem_data_q <= border ? '0 : InData;
                        idx_q      <= idx_q + 1'b1;
                        if (col_q == ColLast) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (last_pos) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MemWE   = mem_we_q;
    assign MemAddr = mem_addr_q;
    assign MemData = mem_data_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - scoreboard bench for pixel_writer at 5x4, 8-bit pixels
// Follows BORDER_FILL_EN when defined for the build.
module tb_pixel_writer;
    localparam int W = 5;
    localparam int H = 4;
    localparam int DB = 8;
    localparam int AB = 16;
`ifdef BORDER_FILL_EN
    localparam int NPOS = W * H;
`else
    localparam int NPOS = (W - 2) * (H - 2);
`endif
    localparam int NI = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          InValid = 1'b0;
    logic [DB-1:0] InData = '0;
    logic          InReady;
    logic          MemWE;
    logic [AB-1:0] MemAddr;
    logic [DB-1:0] MemData;
    logic          Busy;
    logic          Done;

    pixel_writer #(.ImgWidth(W), .ImgHeight(H), .DataBit(DB), .AddrBit(AB)) dut (
        .CLK(clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
        .InReady(InReady), .MemWE(MemWE), .MemAddr(MemAddr), .MemData(MemData),
        .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_border(input int p);
`ifdef BORDER_FILL_EN
        int r, c;
        r = p / W;
        c = p % W;
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
`else
        return (p < 0);
`endif
    endfunction

    task automatic push_frame(input int base);
        int k;
        exp_t e;
        k = 0;
        for (int p = 0; p < NPOS; p++) begin
            e.addr = p;
            e.done = (p == NPOS - 1);
            if (is_border(p)) e.data = 0;
            else begin
                e.data = (base + k) & 8'hff;
                k++;
            end
            sb.push_back(e);
        end
    endtask

    // Feeds one frame; returns at the negedge where Done is visible.
    task automatic feed(input int base, input bit gaps, input int start_at, input bit do_start);
        int k, c, t;
        push_frame(base);
        if (do_start) begin
            @(negedge clk);
            Start = 1'b1;
        end
        k = 0;
        c = 0;
        while (k < NI && c < 200) begin
            @(negedge clk);
            Start = (c == start_at);
            if (gaps && (c % 2 == 1)) InValid = 1'b0;
            else begin
                InValid = 1'b1;
                InData  = DB'(base + k);
            end
            #1;
            if (!gaps) chk("in_ready", InReady, !is_border(c));
            if (InValid && InReady) k++;
            c++;
        end
        @(negedge clk);
        Start   = 1'b0;
        InValid = 1'b0;
        t = 0;
        while (!Done && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", Done, 1);
        chk("busy_at_done", Busy, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (MemWE) begin
            if (sb.size() == 0) chk("unexpected_we", MemAddr, 32'hffff_ffff);
            else begin
                e = sb.pop_front();
                chk("addr", MemAddr, e.addr);
                chk("data", MemData, e.data);
                chk("done", Done, e.done);
            end
        end else if (Done) begin
            chk("done_without_we", Done, 0);
        end
    end

    initial begin
        int k;
        exp_t e;

        // reset held 4 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_outs", {InReady, MemWE, Busy, Done}, 4'b0);
            chk("rst_addr", MemAddr, 0);
            chk("rst_data", MemData, 0);
        end
        Reset = 1'b0;
        // InValid in IDLE ignored
        InValid = 1'b1;
        InData  = 8'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idle_ready", InReady, 0);
            chk("idle_busy", Busy, 0);
        end
        InValid = 1'b0;

        // full-rate frame
        feed(10, 1'b0, -1, 1'b1);
        @(negedge clk);
        chk("busy_fall", Busy, 0);
        chk("sb_empty_1", sb.size(), 0);

        // alternating InValid
        feed(20, 1'b1, -1, 1'b1);
        @(negedge clk);
        chk("busy_fall_2", Busy, 0);
        chk("sb_empty_2", sb.size(), 0);

        // reset mid-frame together with Start
        @(negedge clk);
        Start = 1'b1;
        k = 0;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            Start   = 1'b0;
            InValid = 1'b1;
            InData  = DB'(50 + k);
            e.addr = p;
            e.done = 1'b0;
            e.data = is_border(p) ? 0 : 50 + k;
            if (!is_border(p)) k++;
            sb.push_back(e);
        end
        @(negedge clk);
        Reset = 1'b1;
        Start = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_we", MemWE, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_ready", InReady, 0);
        Reset = 1'b0;
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_idle_ready", InReady, 0);
        end
        InValid = 1'b0;
        chk("sb_empty_3", sb.size(), 0);
        feed(60, 1'b0, -1, 1'b1);
        @(negedge clk);
        chk("busy_fall_3", Busy, 0);

        // Start mid-frame ignored, Start in Done cycle restarts
        feed(70, 1'b0, 3, 1'b1);
        Start = 1'b1;
        feed(80, 1'b0, -1, 1'b0);
        @(negedge clk);
        chk("busy_fall_4", Busy, 0);
        @(negedge clk);
        chk("sb_empty_4", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pixel_writer.md
# pixel_writer

Output-side stream writer for the Sobel pipeline, the counterpart of the input loader. It accepts the edge-magnitude pixel stream with a valid/ready handshake and generates raster-order write addresses, data and write enables for the result memory. It reports Busy while a frame is in progress and pulses Done on the frame's final write. Optionally it synthesises the zero border that the 3x3 kernel cannot produce.

## Interface
- ImgWidth, 256: full image width in pixels (≥3)
- ImgHeight, 256: full image height in pixels (≥3)
- DataBit, 8: pixel width
- AddrBit, 16: memory address width; must satisfy 2^AddrBit ≥ ImgWidth*ImgHeight
- CLK  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin a frame; honoured only in IDLE
- InValid  in  1  InData is valid
- InData  in  DataBit  edge pixel, interior raster order
- InReady  out  1  writer accepts InData this cycle
- MemWE  out  1  result-memory write enable
- MemAddr  out  AddrBit  write address
- MemData  out  DataBit  write data
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse coincident with the frame's last MemWE

## Operation
- States: IDLE, RUN.
- IDLE: InReady=0. Start=1 clears the position counters (Row, Col) and enters RUN.
- RUN traverses positions in raster order (Col fastest). Each position produces exactly one write.
- A position advances on an accepted pixel (InValid & InReady) or on a border fill write (macro only). The last position returns the block to IDLE.
- Interior positions: InReady=1. If InValid=0, the block stalls and the counters hold.
- Address generation:
  - Without the macro, MemAddr = position index, 0..(ImgWidth-2)*(ImgHeight-2)-1.
  - With the macro, MemAddr = Row*ImgWidth+Col over the full image.
- Address arithmetic is unsigned; the counters never wrap inside a frame.
- Start during RUN is ignored. InValid in IDLE is ignored (InReady=0).
- Reset mid-frame aborts the frame. No further writes occur, and partial memory contents are left as written.
- Reset and Start in the same cycle: Reset wins.

## Timing
- Reset values: InReady=0, MemWE=0, MemAddr=0, MemData=0, Busy=0, Done=0, state=IDLE, counters=0.
- InReady is combinational from state and position.
- MemWE, MemAddr, MemData and Done are registered. A write caused in cycle t appears at cycle t+1, asserted for exactly one cycle.
- Busy rises the cycle after Start is accepted. It stays high through the cycle in which Done=1, then falls.
- Throughput: one write per cycle when InValid is held high. Border fills also run at one per cycle.
- Start may be accepted in the cycle Done is high: the state is IDLE by then. The new frame's first write cannot occur before the cycle after that.

## Configuration
- BORDER_FILL_EN defined:
  - The traversal covers the full ImgWidth×ImgHeight frame.
  - Positions with Row∈{0,ImgHeight-1} or Col∈{0,ImgWidth-1} are border positions. At these, InReady=0 and the block writes MemData=0 autonomously, one per cycle.
  - Interior positions take InData.
  - The frame has ImgWidth*ImgHeight writes.
- BORDER_FILL_EN undefined:
  - Only the (ImgWidth-2)×(ImgHeight-2) interior is traversed, with compact addresses 0..N-1 and no fill logic.

## Test plan
All scenarios use ImgWidth=5, ImgHeight=4, DataBit=8.
- Reset held 4 cycles, then released: all outputs 0 and InReady=0 until Start.
- No macro; Start, then InValid=1 with InData=10..15: six writes at addresses 0..5 with data 10..15. Done coincides with the address-5 write. Busy falls the next cycle.
- No macro; InValid toggles 1,0,1,0…: MemWE follows each accepted pixel one cycle later. Addresses stay contiguous with no duplicates. Done appears after the 6th accepted pixel.
- BORDER_FILL_EN; Start, InValid=1, data 1..6:
  - 20 writes at addresses 0..19.
  - Addresses 6,7,8,11,12,13 carry 1..6; all others carry 0.
  - InReady=0 during the first 6 positions.
- Reset asserted after 3 writes, together with Start: no MemWE after Reset, Busy=0, state IDLE, Start ignored. A subsequent Start restarts at address 0.
- Start pulsed during RUN and again in the Done cycle: the mid-frame Start has no effect. The Done-cycle Start begins a new frame from address 0.
